vga_timing_gen: RTL and testbench

Parametrised VGA raster timing generator: the next generation of the fixed 640x480 controller used by the game top level. It produces sync, blanking and draw coordinates for any timing set. The pixel rate is a clock-enable derived from the system clock rather than a generated clock, and single-cycle frame, line and vblank strobes give the game logic a proper clock-enable tick instead of clocking logic from VS. Sits between the 50 MHz clock domain and `color_mapper` / `game`.

---
 rtl/vga_timing_gen_if.sv | 30 +++
 rtl/vga_timing_gen.sv | 150 +++++++++++++++
 tb/tb_vga_timing_gen.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle between vga_timing_gen (master) and its pixel/game consumers (slave).
// XW/YW must match the generator's coordinate widths.
interface vga_timing_gen_if #(
    parameter int XW = 10,
    parameter int YW = 10
);
    logic          Enable;
    logic          pixel_ce;
    logic          hs;
    logic          vs;
    logic          blank;
    logic          sync;
    logic [XW-1:0] DrawX;
    logic [YW-1:0] DrawY;
    logic          frame_start;
    logic          line_start;
    logic          vblank_start;

    modport master (
        input  Enable,
        output pixel_ce, hs, vs, blank, sync, DrawX, DrawY,
               frame_start, line_start, vblank_start
    );

    modport slave (
        output Enable,
        input  pixel_ce, hs, vs, blank, sync, DrawX, DrawY,
               frame_start, line_start, vblank_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster generator: pixel clock-enable divider, h/v counters and
// registered sync/blank/strobe outputs that always describe the current (DrawX,DrawY).
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CLK_DIV  = 2,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int XW       = 10,
    parameter int YW       = 10
) (
    input  logic             Clk,
    input  logic             Reset_n,
    vga_timing_gen_if.master vga
);

    localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_SYNC_LO = H_ACTIVE + H_FP;
    localparam int H_SYNC_HI = H_ACTIVE + H_FP + H_SYNC;
    localparam int V_SYNC_LO = V_ACTIVE + V_FP;
    localparam int V_SYNC_HI = V_ACTIVE + V_FP + V_SYNC;
    localparam int DW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [XW-1:0] H_LAST   = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0] V_LAST   = YW'(V_TOTAL - 1);
    localparam logic [XW-1:0] H_ACT    = XW'(H_ACTIVE);
    localparam logic [YW-1:0] V_ACT    = YW'(V_ACTIVE);

    if (longint'(H_TOTAL - 1) > ((64'sd1 << XW) - 64'sd1)) begin : g_bad_xw
        $fatal(1, "vga_timing_gen: H_TOTAL-1 does not fit in XW bits");
    end
    if (longint'(V_TOTAL - 1) > ((64'sd1 << YW) - 64'sd1)) begin : g_bad_yw
        $fatal(1, "vga_timing_gen: V_TOTAL-1 does not fit in YW bits");
    end
    if (CLK_DIV < 1) begin : g_bad_div
        $fatal(1, "vga_timing_gen: CLK_DIV must be at least 1");
    end
    if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_porch
        $fatal(1, "vga_timing_gen: porch and sync widths must be non-zero");
    end

    function automatic logic in_window(input int v, input int lo, input int hi);
        return (v >= lo) && (v < hi);
    endfunction

    logic [DW-1:0] div_r;
    logic [XW-1:0] hc_r;
    logic [YW-1:0] vc_r;
    logic          hs_r;
    logic          vs_r;
    logic          blank_r;
    logic          sync_r;
    logic          frame_r;
    logic          line_r;
    logic          vblank_r;

    logic          pce_s;
    logic [DW-1:0] div_nxt_s;
    logic [XW-1:0] hc_nxt_s;
    logic [YW-1:0] vc_nxt_s;
    logic          hs_on_s;
    logic          vs_on_s;
    logic          line_nxt_s;

    // Reset gates the enable so pixel_ce stays low while held in reset, even with CLK_DIV=1.
    assign pce_s = vga.Enable & Reset_n & (div_r == DIV_LAST);

    // Next divider and raster position; everything holds while Enable is low.
    always_comb begin
        div_nxt_s = div_r;
        hc_nxt_s  = hc_r;
        vc_nxt_s  = vc_r;
        if (vga.Enable) begin
            if (div_r == DIV_LAST) begin
                div_nxt_s = '0;
            end else begin
                div_nxt_s = div_r + DW'(1);
            end
        end else begin
            div_nxt_s = div_r;
        end
        if (pce_s) begin
            if (hc_r == H_LAST) begin
                hc_nxt_s = '0;
                if (vc_r == V_LAST) begin
                    vc_nxt_s = '0;
                end else begin
                    vc_nxt_s = vc_r + YW'(1);
                end
            end else begin
                hc_nxt_s = hc_r + XW'(1);
                vc_nxt_s = vc_r;
            end
        end else begin
            hc_nxt_s = hc_r;
            vc_nxt_s = vc_r;
        end
    end

    assign hs_on_s    = in_window(int'(hc_nxt_s), H_SYNC_LO, H_SYNC_HI);
    assign vs_on_s    = in_window(int'(vc_nxt_s), V_SYNC_LO, V_SYNC_HI);
    assign line_nxt_s = pce_s & (hc_nxt_s == '0);

    // Counters and outputs register together, decoded from the next position so they stay coherent.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            div_r    <= '0;
            hc_r     <= '0;
            vc_r     <= '0;
            hs_r     <= ~HS_POL;
            vs_r     <= ~VS_POL;
            blank_r  <= 1'b1;
            sync_r   <= 1'b1;
            frame_r  <= 1'b0;
            line_r   <= 1'b0;
            vblank_r <= 1'b0;
        end else begin
            div_r    <= div_nxt_s;
            hc_r     <= hc_nxt_s;
            vc_r     <= vc_nxt_s;
            hs_r     <= hs_on_s ? HS_POL : ~HS_POL;
            vs_r     <= vs_on_s ? VS_POL : ~VS_POL;
            blank_r  <= (hc_nxt_s < H_ACT) && (vc_nxt_s < V_ACT);
            sync_r   <= ~(hs_on_s | vs_on_s);
            frame_r  <= line_nxt_s & (vc_nxt_s == '0);
            line_r   <= line_nxt_s;
            vblank_r <= line_nxt_s & (vc_nxt_s == V_ACT);
        end
    end

    assign vga.pixel_ce     = pce_s;
    assign vga.hs           = hs_r;
    assign vga.vs           = vs_r;
    assign vga.blank        = blank_r;
    assign vga.sync         = sync_r;
    assign vga.DrawX        = hc_r;
    assign vga.DrawY        = vc_r;
    assign vga.frame_start  = frame_r;
    assign vga.line_start   = line_r;
    assign vga.vblank_start = vblank_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two small timing sets checked every cycle against a model that
// derives the raster position arithmetically from the count of enabled clock edges.
module tb_vga_timing_gen;

    localparam int A_HA = 4,  A_HFP = 1, A_HS = 1, A_HBP = 1;
    localparam int A_VA = 3,  A_VFP = 1, A_VS = 1, A_VBP = 1, A_DIV = 1;
    localparam int B_HA = 10, B_HFP = 2, B_HS = 3, B_HBP = 4;
    localparam int B_VA = 6,  B_VFP = 1, B_VS = 2, B_VBP = 2, B_DIV = 3;

    typedef struct {
        int ha, hfp, hsw, hbp, va, vfp, vsw, vbp, dv;
        bit hpol, vpol;
    } cfg_t;

    logic clk;
    logic rst_n;
    logic en;

    cfg_t cfg [2];
    bit   adv [2];
    int   n;
    int   cyc;
    int   checks;
    int   errors;

    vga_timing_gen_if #(.XW(10), .YW(10)) ifa ();
    vga_timing_gen_if #(.XW(10), .YW(10)) ifb ();

    assign ifa.Enable = en;
    assign ifb.Enable = en;

    vga_timing_gen #(
        .H_ACTIVE(A_HA), .H_FP(A_HFP), .H_SYNC(A_HS), .H_BP(A_HBP),
        .V_ACTIVE(A_VA), .V_FP(A_VFP), .V_SYNC(A_VS), .V_BP(A_VBP),
        .CLK_DIV(A_DIV), .HS_POL(1'b1), .VS_POL(1'b1), .XW(10), .YW(10)
    ) dut_a (.Clk(clk), .Reset_n(rst_n), .vga(ifa));

    vga_timing_gen #(
        .H_ACTIVE(B_HA), .H_FP(B_HFP), .H_SYNC(B_HS), .H_BP(B_HBP),
        .V_ACTIVE(B_VA), .V_FP(B_VFP), .V_SYNC(B_VS), .V_BP(B_VBP),
        .CLK_DIV(B_DIV), .HS_POL(1'b0), .VS_POL(1'b0), .XW(10), .YW(10)
    ) dut_b (.Clk(clk), .Reset_n(rst_n), .vga(ifb));

    logic [27:0] act_a;
    logic [27:0] act_b;
    assign act_a = {ifa.pixel_ce, ifa.hs, ifa.vs, ifa.blank, ifa.sync,
                    ifa.frame_start, ifa.line_start, ifa.vblank_start, ifa.DrawX, ifa.DrawY};
    assign act_b = {ifb.pixel_ce, ifb.hs, ifb.vs, ifb.blank, ifb.sync,
                    ifb.frame_start, ifb.line_start, ifb.vblank_start, ifb.DrawX, ifb.DrawY};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected outputs: position is pixel index n/div folded into the h/v totals.
    function automatic logic [27:0] model_out(input cfg_t c, input int n_i, input bit adv_i,
                                              input bit en_i, input bit rn_i);
        int ht, vt, p, x, y;
        bit hsa, vsa, ls;
        ht  = c.ha + c.hfp + c.hsw + c.hbp;
        vt  = c.va + c.vfp + c.vsw + c.vbp;
        p   = n_i / c.dv;
        x   = p % ht;
        y   = (p / ht) % vt;
        hsa = (x >= c.ha + c.hfp) && (x < c.ha + c.hfp + c.hsw);
        vsa = (y >= c.va + c.vfp) && (y < c.va + c.vfp + c.vsw);
        ls  = adv_i && (x == 0);
        return {en_i && rn_i && ((n_i % c.dv) == c.dv - 1),
                hsa ? c.hpol : ~c.hpol,
                vsa ? c.vpol : ~c.vpol,
                (x < c.ha) && (y < c.va),
                ~(hsa | vsa),
                ls && (y == 0),
                ls,
                ls && (y == c.va),
                10'(x), 10'(y)};
    endfunction

    task automatic check_all();
        logic [27:0] exp_v;
        logic [27:0] got_v;
        for (int i = 0; i < 2; i++) begin
            exp_v = model_out(cfg[i], n, adv[i], en, rst_n);
            got_v = (i == 0) ? act_a : act_b;
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL outputs dut%0d cyc=%0d got=%h exp=%h (pce,hs,vs,blank,sync,fs,ls,vb,x,y)",
                         i, cyc, got_v, exp_v);
            end
        end
    endtask

    task automatic pin(input string name, input int got, input int exp_v);
        checks++;
        if (got != exp_v) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            adv[i] = rst_n && en && ((n % cfg[i].dv) == cfg[i].dv - 1);
        end
        if (!rst_n) n = 0;
        else if (en) n++;
        cyc++;
        @(negedge clk);
        check_all();
    endtask

    int a_fs1, a_fs2, a_vb1, b_ls1, b_fs1, b_vb1;
    int a_hs_cnt, a_vs_cnt, a_sync_lo;
    int t0, t1;
    int r;

    initial begin
        cfg[0] = '{A_HA, A_HFP, A_HS, A_HBP, A_VA, A_VFP, A_VS, A_VBP, A_DIV, 1'b1, 1'b1};
        cfg[1] = '{B_HA, B_HFP, B_HS, B_HBP, B_VA, B_VFP, B_VS, B_VBP, B_DIV, 1'b0, 1'b0};
        checks = 0; errors = 0; n = 0; cyc = 0;
        adv[0] = 1'b0; adv[1] = 1'b0;
        a_fs1 = -1; a_fs2 = -1; a_vb1 = -1; b_ls1 = -1; b_fs1 = -1; b_vb1 = -1;
        a_hs_cnt = 0; a_vs_cnt = 0; a_sync_lo = 0;
        rst_n = 1'b1;
        en    = 1'b0;

        // Reset with Enable high: pixel_ce must still read 0
        #3 rst_n = 1'b0;
        en = 1'b1;
        #1 check_all();
        repeat (3) tick();
        rst_n = 1'b1;

        // Free-running phase with event timing pinned to hand-computed edge counts
        for (int k = 0; k < 700; k++) begin
            tick();
            if (ifa.frame_start) begin
                if (a_fs1 < 0) a_fs1 = n;
                else if (a_fs2 < 0) a_fs2 = n;
            end
            if (ifa.vblank_start && a_vb1 < 0) a_vb1 = n;
            if (ifb.line_start && b_ls1 < 0) b_ls1 = n;
            if (ifb.frame_start && b_fs1 < 0) b_fs1 = n;
            if (ifb.vblank_start && b_vb1 < 0) b_vb1 = n;
            if (n <= 42) begin
                a_hs_cnt  += int'(ifa.hs);
                a_vs_cnt  += int'(ifa.vs);
                a_sync_lo += int'(!ifa.sync);
            end
        end
        pin("a_first_frame_start", a_fs1, 42);
        pin("a_second_frame_start", a_fs2, 84);
        pin("a_first_vblank_start", a_vb1, 21);
        pin("a_hs_cycles_per_frame", a_hs_cnt, 6);
        pin("a_vs_cycles_per_frame", a_vs_cnt, 7);
        pin("a_sync_low_per_frame", a_sync_lo, 12);
        pin("b_first_line_start", b_ls1, 57);
        pin("b_first_frame_start", b_fs1, 627);
        pin("b_first_vblank_start", b_vb1, 342);

        // Enable dropped for 7 cycles mid-line stretches that line by exactly 7 clocks
        t0 = -1;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (ifb.line_start) begin
                t0 = cyc;
                break;
            end
        end
        for (int k = 0; k < 200; k++) begin
            if (ifb.DrawX == 10'd7) break;
            tick();
        end
        en = 1'b0;
        repeat (7) tick();
        en = 1'b1;
        t1 = -1;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (ifb.line_start) begin
                t1 = cyc;
                break;
            end
        end
        pin("b_line_period_with_hold", (t0 < 0 || t1 < 0) ? -1 : t1 - t0, 64);

        // Random Enable with occasional asynchronous reset pulses
        for (int k = 0; k < 3000; k++) begin
            r  = int'($urandom_range(0, 99));
            en = (r < 80);
            if (r == 99) begin
                rst_n = 1'b0;
                n = 0;
                adv[0] = 1'b0;
                adv[1] = 1'b0;
                #1 check_all();
                repeat (int'($urandom_range(1, 3))) tick();
                rst_n = 1'b1;
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
